// File: rtl/construtor_caminho_pkg.sv
// Shared definitions for the path-construction stage: FSM encodings,
// default geometry and the stack count-width helper.
package construtor_caminho_pkg;

    localparam int STATE_WIDTH    = 3;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_MAX_PATH   = 64;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_PRONTO = 3'd3,
        ST_ERRO   = 3'd4
    } estado_t;

    // Bits needed to hold a node count in the range 0..max_path inclusive.
    function automatic int count_width(input int max_path);
        return $clog2(max_path + 1);
    endfunction

endpackage

// File: rtl/construtor_caminho_pilha.sv
// LIFO of node ids used to reverse the destination-to-source walk.
// Clear beats push, push beats pop; push when full and pop when empty are dropped.
module pilha_caminho
    import construtor_caminho_pkg::*;
#(
    parameter  int WIDTH = DEF_ADDR_WIDTH,
    parameter  int DEPTH = DEF_MAX_PATH,
    localparam int CW    = count_width(DEPTH),
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_in,
    input  logic             push_in,
    input  logic             pop_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] top_out,
    output logic [CW-1:0]    count_out,
    output logic             full_out,
    output logic             empty_out
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [IW-1:0]    wr_idx_s;
    logic [IW-1:0]    rd_idx_s;

    assign full_out  = (count_q == CW'(DEPTH));
    assign empty_out = (count_q == {CW{1'b0}});
    assign count_out = count_q;
    assign wr_idx_s  = IW'(count_q);
    assign rd_idx_s  = IW'(count_q - CW'(1));
    assign top_out   = empty_out ? {WIDTH{1'b0}} : mem_q[rd_idx_s];

    // Next stack contents and occupancy from the clear/push/pop requests.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (clear_in) begin
            count_d = {CW{1'b0}};
        end else if (push_in && !full_out) begin
            mem_d[wr_idx_s] = data_in;
            count_d         = count_q + CW'(1);
        end else if (pop_in && !empty_out) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Stack storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            count_q <= {CW{1'b0}};
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/construtor_caminho.sv
// Path-construction stage: walks the predecessor memory from destination back
// to source, stacks every node, then streams the path source-first until the
// controller acknowledges.
module construtor_caminho
    import construtor_caminho_pkg::*;
#(
    parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter  int MAX_PATH   = DEF_MAX_PATH,
    localparam int CW         = count_width(MAX_PATH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iniciar_in,
    input  logic                  construir_caminho_in,
    input  logic [ADDR_WIDTH-1:0] fonte_in,
    input  logic [ADDR_WIDTH-1:0] destino_in,
    output logic                  pred_rd_en_out,
    output logic [ADDR_WIDTH-1:0] pred_addr_out,
    input  logic [ADDR_WIDTH-1:0] pred_data_in,
    input  logic                  pred_valid_in,
    output logic                  caminho_pronto_out,
    output logic                  erro_out,
    output logic                  caminho_valid_out,
    output logic [ADDR_WIDTH-1:0] caminho_node_out,
    output logic                  caminho_fim_out,
    input  logic                  caminho_rd_in,
    input  logic                  lido_in
);

    estado_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0] fonte_q, fonte_d;
    logic [ADDR_WIDTH-1:0] atual_q, atual_d;
    logic                  pred_rd_en_q, pred_rd_en_d;
    logic [ADDR_WIDTH-1:0] pred_addr_q, pred_addr_d;

    logic                  stk_clear_s;
    logic                  stk_push_s;
    logic                  stk_pop_s;
    logic [ADDR_WIDTH-1:0] stk_data_s;
    logic [ADDR_WIDTH-1:0] stk_top_s;
    logic [CW-1:0]         stk_count_s;
    logic                  stk_full_s;
    logic                  stk_empty_s;

    pilha_caminho #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (MAX_PATH)
    ) u_pilha (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_in  (stk_clear_s),
        .push_in   (stk_push_s),
        .pop_in    (stk_pop_s),
        .data_in   (stk_data_s),
        .top_out   (stk_top_s),
        .count_out (stk_count_s),
        .full_out  (stk_full_s),
        .empty_out (stk_empty_s)
    );

    // State, walk bookkeeping and registered memory-request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fonte_q      <= {ADDR_WIDTH{1'b0}};
            atual_q      <= {ADDR_WIDTH{1'b0}};
            pred_rd_en_q <= 1'b0;
            pred_addr_q  <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            fonte_q      <= fonte_d;
            atual_q      <= atual_d;
            pred_rd_en_q <= pred_rd_en_d;
            pred_addr_q  <= pred_addr_d;
        end
    end

    // Next state and stack commands; iniciar_in overrides everything else.
    always_comb begin
        state_d     = state_q;
        fonte_d     = fonte_q;
        atual_d     = atual_q;
        stk_clear_s = 1'b0;
        stk_push_s  = 1'b0;
        stk_pop_s   = 1'b0;
        stk_data_s  = {ADDR_WIDTH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (construir_caminho_in) begin
                    fonte_d    = fonte_in;
                    atual_d    = destino_in;
                    stk_push_s = 1'b1;
                    stk_data_s = destino_in;
                    state_d    = (destino_in == fonte_in) ? ST_PRONTO : ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!pred_valid_in) begin
                    state_d = ST_ERRO;
                end else if (stk_full_s) begin
                    state_d = ST_ERRO;
                end else begin
                    stk_push_s = 1'b1;
                    stk_data_s = pred_data_in;
                    atual_d    = pred_data_in;
                    state_d    = (pred_data_in == fonte_q) ? ST_PRONTO : ST_REQ;
                end
            end
            ST_PRONTO: begin
                if (lido_in) begin
                    stk_clear_s = 1'b1;
                    state_d     = ST_IDLE;
                end else if (caminho_rd_in && !stk_empty_s) begin
                    stk_pop_s = 1'b1;
                end else begin
                    state_d = ST_PRONTO;
                end
            end
            ST_ERRO: begin
                if (lido_in) begin
                    stk_clear_s = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_ERRO;
                end
            end
            default: begin
                stk_clear_s = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
        if (iniciar_in) begin
            stk_clear_s = 1'b1;
            stk_push_s  = 1'b0;
            stk_pop_s   = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            stk_clear_s = stk_clear_s;
        end
    end

    // Status and stream outputs, plus the next value of the memory request.
    always_comb begin
        caminho_pronto_out = (state_q == ST_PRONTO) || (state_q == ST_ERRO);
        erro_out           = (state_q == ST_ERRO);
        caminho_valid_out  = (state_q == ST_PRONTO) && !stk_empty_s;
        caminho_node_out   = caminho_valid_out ? stk_top_s : {ADDR_WIDTH{1'b0}};
        caminho_fim_out    = caminho_valid_out && (stk_count_s == CW'(1));
        pred_rd_en_d       = (state_d == ST_REQ);
        pred_addr_d        = pred_rd_en_d ? atual_d : {ADDR_WIDTH{1'b0}};
    end

    assign pred_rd_en_out = pred_rd_en_q;
    assign pred_addr_out  = pred_addr_q;

endmodule

// File: tb/tb_construtor_caminho.sv
// Directed bench for construtor_caminho: one instance at MAX_PATH 64 and one at
// MAX_PATH 4 share stimulus; each has its own predecessor-memory responder.
module tb_construtor_caminho;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, iniciar, construir, rd, lido;
    logic [7:0] fonte, destino;

    logic       a_rd_en, a_pvalid, a_pronto, a_erro, a_valid, a_fim;
    logic [7:0] a_addr, a_pdata, a_node;
    logic       b_rd_en, b_pvalid, b_pronto, b_erro, b_valid, b_fim;
    logic [7:0] b_addr, b_pdata, b_node;

    logic [7:0] pm_data [256];
    logic       pm_ok   [256];

    logic [11:0] a_obs, b_obs;
    assign a_obs = {a_pronto, a_erro, a_valid, a_fim, a_node};
    assign b_obs = {b_pronto, b_erro, b_valid, b_fim, b_node};

    int n_checks = 0;
    int n_fail   = 0;

    construtor_caminho #(.ADDR_WIDTH(8), .MAX_PATH(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .iniciar_in(iniciar), .construir_caminho_in(construir),
        .fonte_in(fonte), .destino_in(destino), .pred_rd_en_out(a_rd_en), .pred_addr_out(a_addr),
        .pred_data_in(a_pdata), .pred_valid_in(a_pvalid), .caminho_pronto_out(a_pronto),
        .erro_out(a_erro), .caminho_valid_out(a_valid), .caminho_node_out(a_node),
        .caminho_fim_out(a_fim), .caminho_rd_in(rd), .lido_in(lido)
    );

    construtor_caminho #(.ADDR_WIDTH(8), .MAX_PATH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .iniciar_in(iniciar), .construir_caminho_in(construir),
        .fonte_in(fonte), .destino_in(destino), .pred_rd_en_out(b_rd_en), .pred_addr_out(b_addr),
        .pred_data_in(b_pdata), .pred_valid_in(b_pvalid), .caminho_pronto_out(b_pronto),
        .erro_out(b_erro), .caminho_valid_out(b_valid), .caminho_node_out(b_node),
        .caminho_fim_out(b_fim), .caminho_rd_in(rd), .lido_in(lido)
    );

    // Predecessor memories: synchronous read, data present only the cycle after a strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_pdata <= 8'd0; a_pvalid <= 1'b0;
            b_pdata <= 8'd0; b_pvalid <= 1'b0;
        end else begin
            a_pdata  <= a_rd_en ? pm_data[a_addr] : 8'd0;
            a_pvalid <= a_rd_en ? pm_ok[a_addr]   : 1'b0;
            b_pdata  <= b_rd_en ? pm_data[b_addr] : 8'd0;
            b_pvalid <= b_rd_en ? pm_ok[b_addr]   : 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] f, input logic [7:0] d);
        fonte = f; destino = d; construir = 1'b1;
        tick();
        construir = 1'b0;
    endtask

    task automatic ack();
        lido = 1'b1;
        tick();
        lido = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            pm_data[i] = 8'd0;
            pm_ok[i]   = 1'b0;
        end
    endtask

    task automatic set_pred(input logic [7:0] n, input logic [7:0] p);
        pm_data[n] = p;
        pm_ok[n]   = 1'b1;
    endtask

    task automatic load_chain9();
        clear_mem();
        set_pred(8'd9, 8'd7); set_pred(8'd7, 8'd3); set_pred(8'd3, 8'd1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iniciar = 1'b0; construir = 1'b0; rd = 1'b0; lido = 1'b0;
        fonte = 8'd0; destino = 8'd0;
        clear_mem();
        #3;
        n_checks++;
        if (a_obs !== 12'h000) begin n_fail++; $display("FAIL reset_stream_a obs=%h exp=%h", a_obs, 12'h000); end
        n_checks++;
        if ({a_rd_en, a_addr} !== 9'h000) begin n_fail++; $display("FAIL reset_pred_a got=%h exp=%h", {a_rd_en, a_addr}, 9'h000); end
        n_checks++;
        if (b_obs !== 12'h000) begin n_fail++; $display("FAIL reset_stream_b obs=%h exp=%h", b_obs, 12'h000); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        start(8'd5, 8'd5);
        n_checks++;
        if (a_obs !== 12'hB05) begin n_fail++; $display("FAIL single_node obs=%h exp=%h", a_obs, 12'hB05); end
        ack();
        n_checks++;
        if (a_obs !== 12'h000) begin n_fail++; $display("FAIL single_ack obs=%h exp=%h", a_obs, 12'h000); end
    endtask

    task automatic test_chain();
        logic [7:0] ep [4];
        ep = '{8'd1, 8'd3, 8'd7, 8'd9};
        load_chain9();
        start(8'd1, 8'd9);
        n_checks++;
        if ({a_rd_en, a_addr} !== 9'h109) begin n_fail++; $display("FAIL chain_first_req got=%h exp=%h", {a_rd_en, a_addr}, 9'h109); end
        for (int j = 1; j <= 6; j++) begin
            tick();
            n_checks++;
            if (a_pronto !== (j == 6)) begin n_fail++; $display("FAIL chain_pronto_timing cycle=%0d got=%b exp=%b", j, a_pronto, (j == 6)); end
        end
        rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (a_obs !== {1'b1, 1'b0, 1'b1, (i == 3), ep[i]}) begin
                n_fail++; $display("FAIL chain_stream idx=%0d obs=%h exp=%h", i, a_obs, {1'b1, 1'b0, 1'b1, (i == 3), ep[i]});
            end
            tick();
        end
        n_checks++;
        if (a_obs !== 12'h800) begin n_fail++; $display("FAIL chain_drained obs=%h exp=%h", a_obs, 12'h800); end
        tick();
        n_checks++;
        if (a_obs !== 12'h800) begin n_fail++; $display("FAIL chain_pop_empty obs=%h exp=%h", a_obs, 12'h800); end
        rd = 1'b0;
        ack();
        n_checks++;
        if (a_obs !== 12'h000) begin n_fail++; $display("FAIL chain_ack obs=%h exp=%h", a_obs, 12'h000); end
    endtask

    task automatic test_error();
        clear_mem();
        set_pred(8'd20, 8'd21);
        start(8'd99, 8'd20);
        for (int j = 1; j <= 4; j++) begin
            tick();
            n_checks++;
            if (a_obs !== ((j == 4) ? 12'hC00 : 12'h000)) begin
                n_fail++; $display("FAIL error_walk cycle=%0d obs=%h exp=%h", j, a_obs, ((j == 4) ? 12'hC00 : 12'h000));
            end
        end
        ack();
        n_checks++;
        if (a_obs !== 12'h000) begin n_fail++; $display("FAIL error_ack obs=%h exp=%h", a_obs, 12'h000); end
    endtask

    task automatic test_overflow();
        clear_mem();
        set_pred(8'd50, 8'd40); set_pred(8'd40, 8'd30);
        set_pred(8'd30, 8'd20); set_pred(8'd20, 8'd10);
        start(8'd10, 8'd50);
        for (int j = 1; j <= 7; j++) tick();
        n_checks++;
        if (b_pronto !== 1'b0) begin n_fail++; $display("FAIL overflow_early got=%b exp=%b", b_pronto, 1'b0); end
        tick();
        n_checks++;
        if (b_obs !== 12'hC00) begin n_fail++; $display("FAIL overflow_small obs=%h exp=%h", b_obs, 12'hC00); end
        n_checks++;
        if (a_obs !== 12'hA0A) begin n_fail++; $display("FAIL overflow_big_ok obs=%h exp=%h", a_obs, 12'hA0A); end
        tick(); tick();
        n_checks++;
        if (b_obs !== 12'hC00) begin n_fail++; $display("FAIL overflow_hold obs=%h exp=%h", b_obs, 12'hC00); end
        ack();
        n_checks++;
        if ({a_obs, b_obs} !== 24'h000000) begin n_fail++; $display("FAIL overflow_ack obs=%h exp=%h", {a_obs, b_obs}, 24'h000000); end
    endtask

    task automatic test_iniciar();
        logic [7:0] ep [3];
        ep = '{8'd1, 8'd3, 8'd7};
        load_chain9();
        start(8'd1, 8'd9);
        tick();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_checks++;
        if ({a_rd_en, a_addr, a_obs} !== 21'h0) begin n_fail++; $display("FAIL iniciar_abort got=%h exp=%h", {a_rd_en, a_addr, a_obs}, 21'h0); end
        tick();
        n_checks++;
        if ({a_rd_en, a_obs} !== 13'h0) begin n_fail++; $display("FAIL iniciar_idle got=%h exp=%h", {a_rd_en, a_obs}, 13'h0); end
        start(8'd1, 8'd7);
        for (int j = 1; j <= 4; j++) tick();
        rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (a_obs !== {1'b1, 1'b0, 1'b1, (i == 2), ep[i]}) begin
                n_fail++; $display("FAIL iniciar_restart idx=%0d obs=%h exp=%h", i, a_obs, {1'b1, 1'b0, 1'b1, (i == 2), ep[i]});
            end
            tick();
        end
        rd = 1'b0;
        ack();
    endtask

    task automatic test_lido_rd();
        load_chain9();
        start(8'd1, 8'd9);
        for (int j = 1; j <= 6; j++) tick();
        rd = 1'b1; tick(); rd = 1'b0;
        n_checks++;
        if (a_obs !== 12'hA03) begin n_fail++; $display("FAIL lidord_popped obs=%h exp=%h", a_obs, 12'hA03); end
        lido = 1'b1; rd = 1'b1;
        tick();
        lido = 1'b0; rd = 1'b0;
        n_checks++;
        if (a_obs !== 12'h000) begin n_fail++; $display("FAIL lidord_idle obs=%h exp=%h", a_obs, 12'h000); end
        start(8'd5, 8'd5);
        n_checks++;
        if (a_obs !== 12'hB05) begin n_fail++; $display("FAIL lidord_count_cleared obs=%h exp=%h", a_obs, 12'hB05); end
        rd = 1'b1; tick(); rd = 1'b0;
        n_checks++;
        if (a_obs !== 12'h800) begin n_fail++; $display("FAIL lidord_single_pop obs=%h exp=%h", a_obs, 12'h800); end
        ack();
    endtask

    task automatic test_async_reset();
        load_chain9();
        start(8'd1, 8'd9);
        for (int j = 1; j <= 6; j++) tick();
        rd = 1'b1; tick(); rd = 1'b0;
        n_checks++;
        if (a_obs !== 12'hA03) begin n_fail++; $display("FAIL async_pre obs=%h exp=%h", a_obs, 12'hA03); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_rd_en, a_addr, a_obs} !== 21'h0) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", {a_rd_en, a_addr, a_obs}, 21'h0); end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (a_obs !== 12'h000) begin n_fail++; $display("FAIL async_after obs=%h exp=%h", a_obs, 12'h000); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_error();
        test_overflow();
        test_iniciar();
        test_lido_rd();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/construtor_caminho.md
# construtor_caminho

Path-construction stage directly downstream of the top-level control state machine. While `construir_caminho_in` is high, it walks the predecessor memory from `destino_in` back to `fonte_in` and stacks each node. When the walk ends, it raises `caminho_pronto_out`, which feeds the controller's `caminho_pronto_in`. It then streams the path in source-to-destination order until the controller acknowledges with `lido_in`.

## Interface
- `ADDR_WIDTH`, 8: node-id width in bits.
- `MAX_PATH`, 64: stack depth in nodes. Minimum 2.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous reset, active-low.
- `iniciar_in`  in  1: abort or restart from the controller. Highest priority.
- `construir_caminho_in`  in  1: level start, from the controller's `construir_caminho_out`.
- `fonte_in`, `destino_in`  in  ADDR_WIDTH: source and destination node ids. Sampled at start.
- `pred_rd_en_out`  out  1: predecessor-memory read strobe.
- `pred_addr_out`  out  ADDR_WIDTH: predecessor-memory read address.
- `pred_data_in`  in  ADDR_WIDTH: predecessor of the addressed node. Valid 1 cycle after the strobe.
- `pred_valid_in`  in  1: addressed node has a predecessor. Same timing as `pred_data_in`.
- `caminho_pronto_out`  out  1: walk finished, either success or error.
- `erro_out`  out  1: path unreachable or stack overflow. Qualified by `caminho_pronto_out`.
- `caminho_valid_out`  out  1: `caminho_node_out` is valid.
- `caminho_node_out`  out  ADDR_WIDTH: current path node, source first. Reads 0 when not valid.
- `caminho_fim_out`  out  1: current node is the destination, i.e. the last node.
- `caminho_rd_in`  in  1: consume the current node.
- `lido_in`  in  1: controller acknowledge. Returns the block to idle.

## Operation
- States: ST_IDLE, ST_REQ, ST_WAIT, ST_PRONTO, ST_ERRO.
- ST_IDLE with `construir_caminho_in` high:
  - register `fonte_in`; `atual` ← `destino_in`; push `destino_in` (count = 1).
  - go to ST_PRONTO if destino == fonte, otherwise ST_REQ.
- ST_REQ:
  - `pred_rd_en_out` = 1 and `pred_addr_out` = `atual`, both registered outputs;
  - go to ST_WAIT.
- ST_WAIT samples `pred_data_in` and `pred_valid_in`, then:
  - if `pred_valid_in` = 0: go to ST_ERRO;
  - else if count == MAX_PATH: go to ST_ERRO (overflow);
  - else push `pred_data_in` and set `atual` ← `pred_data_in`;
  - go to ST_PRONTO if `pred_data_in` == fonte, otherwise ST_REQ.
- ST_PRONTO: `caminho_pronto_out` = 1.
  - `caminho_valid_out` = (count ≠ 0); `caminho_node_out` = top of stack.
  - `caminho_fim_out` = valid && count == 1.
  - `caminho_rd_in` && valid pops one entry. `caminho_rd_in` with count 0 is ignored.
  - `lido_in` returns to ST_IDLE and clears count, whether or not the stack has been drained.
- ST_ERRO: `caminho_pronto_out` = 1 and `erro_out` = 1; stream outputs are low.
  - `lido_in` returns to ST_IDLE and clears count.
- `iniciar_in` high, from any state: go to ST_IDLE next edge, clear count, deassert all outputs. It overrides `lido_in`, `caminho_rd_in` and the start condition.
- `lido_in` and `caminho_rd_in` in the same cycle: `lido_in` wins; no separate pop is performed.
- `construir_caminho_in` is ignored outside ST_IDLE.
- Count width is clog2(MAX_PATH+1). Push never exceeds MAX_PATH; pop never goes below 0.

## Timing
- Reset: state = ST_IDLE, count = 0, `atual` = 0.
  - All outputs read 0: `pred_rd_en_out`, `pred_addr_out`, `caminho_pronto_out`, `erro_out`, `caminho_valid_out`, `caminho_node_out`, `caminho_fim_out`.
- Asserting `rst_n` low mid-walk or mid-readout takes effect immediately; no pending read is honored.
- Each hop costs 2 cycles: REQ, then WAIT.
- For a path of N nodes where start is sampled at edge k, `caminho_pronto_out` rises after edge k + 2(N−1).
  - N = 1: high after edge k.
- Stream outputs are combinational from state and stack, so they are valid in the same cycle `caminho_pronto_out` rises.
- A pop takes effect at the edge where `caminho_rd_in` is high; the next node is presented in the following cycle. Throughput is one node per cycle.
- Predecessor memory contract: synchronous read, 1-cycle latency, no backpressure.

## Structure
- Shared package holds:
  - the state encodings, STATE_WIDTH = 3;
  - default ADDR_WIDTH and MAX_PATH;
  - the count-width function.
- Sub-module `pilha_caminho`: parameterised LIFO with push, pop, clear, top, count, full and empty.
  - Register array; combinational top.
  - Clear has priority over push and pop.
- The walk FSM lives in `construtor_caminho`.

## Test plan
- destino = fonte = 5 -> `caminho_pronto_out` 1 cycle after start. One node, 5, shown with `caminho_fim_out` = 1. `erro_out` = 0.
- Chain 9→7→3→1 with fonte = 1 and destino = 9 -> pronto after 6 cycles. Stream is 1, 3, 7, 9 with `caminho_rd_in` held high; fim on 9. `lido_in` returns to idle.
- `pred_valid_in` = 0 on the second hop -> ST_ERRO with `erro_out` = 1 and `caminho_valid_out` = 0. `lido_in` clears.
- MAX_PATH = 4 with a 5-node chain -> overflow: `erro_out` = 1 after the 4th push attempt. Count stays 4 until `lido_in`.
- `iniciar_in` pulsed mid-walk in ST_WAIT -> ST_IDLE next edge; all outputs 0. A new start walks correctly.
- `lido_in` and `caminho_rd_in` together with 3 nodes left -> idle, count 0, no extra pop. Async `rst_n` low mid-readout -> all outputs 0 immediately.
